alu_multicycle: RTL and testbench

Parametrised, multi-cycle successor to the phase-1 combinational ALU. Operands and opcode are latched on a `start` pulse. Logic, shift and add/sub ops complete in one cycle. Signed multiply (radix-2 Booth) and signed divide (restoring) iterate one bit per cycle. The block sits between the A/B operand registers and the HI/LO result registers of the datapath, and the control unit waits on `done`.

---
 rtl/alu_multicycle.sv | 242 ++++++++++++++++++++++++
 tb/tb_alu_multicycle.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/shift/add ops, radix-2 Booth multiply and
// restoring signed divide iterating one bit per clock, with registered result and handshake.
module alu_multicycle #(
    parameter int unsigned WORD_SIZE = 32
) (
    input  logic                     clk,
    input  logic                     clr_n,
    input  logic                     start,
    input  logic [4:0]               opcode,
    input  logic [WORD_SIZE-1:0]     a,
    input  logic [WORD_SIZE-1:0]     b,
    output logic                     busy,
    output logic                     done,
    output logic [2*WORD_SIZE-1:0]   c,
    output logic                     div_by_zero
);

    localparam int unsigned W  = WORD_SIZE;
    localparam int unsigned LW = $clog2(WORD_SIZE);

    localparam logic [4:0] OP_ADD  = 5'b00001;
    localparam logic [4:0] OP_SUB  = 5'b00010;
    localparam logic [4:0] OP_MUL  = 5'b00011;
    localparam logic [4:0] OP_DIV  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] OP_SHRA = 5'b00111;
    localparam logic [4:0] OP_ROR  = 5'b01000;
    localparam logic [4:0] OP_ROL  = 5'b01001;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_NEG  = 5'b01100;
    localparam logic [4:0] OP_XOR  = 5'b01101;
    localparam logic [4:0] OP_NOR  = 5'b01110;
    localparam logic [4:0] OP_NOT  = 5'b01111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [LW-1:0]  cnt_q, cnt_d;
    logic [W:0]     mcand_q, mcand_d;
    logic [W:0]     acc_q, acc_d;
    logic [W-1:0]   mq_q, mq_d;
    logic           qm1_q, qm1_d;
    logic [W-1:0]   dvs_q, dvs_d;
    logic [W-1:0]   rem_q, rem_d;
    logic [W-1:0]   quo_q, quo_d;
    logic           neg_quo_q, neg_quo_d;
    logic           neg_rem_q, neg_rem_d;
    logic           busy_d, done_d, dbz_d;
    logic [2*W-1:0] c_d;

    // Single-cycle operation result (LO half); HI is always zero for these
    logic [LW-1:0] shamt;
    logic [LW-1:0] rol_amt;
    logic [W-1:0]  alu_lo;

    assign shamt   = b[LW-1:0];
    assign rol_amt = LW'(0) - shamt;

    always_comb begin
        alu_lo = '0;
        case (opcode)
            OP_ADD:  alu_lo = a + b;
            OP_SUB:  alu_lo = a - b;
            OP_SHR:  alu_lo = a >> shamt;
            OP_SHL:  alu_lo = a << shamt;
            OP_SHRA: alu_lo = $signed(a) >>> shamt;
            OP_ROR:  alu_lo = W'({a, a} >> shamt);
            OP_ROL:  alu_lo = W'({a, a} >> rol_amt);
            OP_AND:  alu_lo = a & b;
            OP_OR:   alu_lo = a | b;
            OP_NEG:  alu_lo = W'(0) - a;
            OP_XOR:  alu_lo = a ^ b;
            OP_NOR:  alu_lo = ~(a | b);
            OP_NOT:  alu_lo = ~a;
            default: alu_lo = '0;
        endcase
    end

    // Booth step: add/subtract multiplicand, then arithmetic shift of {acc, mq, qm1}
    logic [W:0]   booth_sum;
    logic [W:0]   booth_acc;
    logic [W-1:0] booth_mq;

    always_comb begin
        booth_sum = acc_q;
        case ({mq_q[0], qm1_q})
            2'b01:   booth_sum = acc_q + mcand_q;
            2'b10:   booth_sum = acc_q - mcand_q;
            default: booth_sum = acc_q;
        endcase
    end

    assign booth_acc = {booth_sum[W], booth_sum[W:1]};
    assign booth_mq  = {booth_sum[0], mq_q[W-1:1]};

    // Restoring divide step on magnitudes; remainder always stays below the divisor
    logic [W:0]   div_shift;
    logic         div_fit;
    logic [W-1:0] div_rem;
    logic [W-1:0] div_quo;
    logic [W-1:0] quo_fix;
    logic [W-1:0] rem_fix;

    assign div_shift = {rem_q, quo_q[W-1]};
    assign div_fit   = (div_shift >= {1'b0, dvs_q});
    assign div_rem   = div_fit ? (div_shift[W-1:0] - dvs_q) : div_shift[W-1:0];
    assign div_quo   = {quo_q[W-2:0], div_fit};
    assign quo_fix   = neg_quo_q ? (W'(0) - div_quo) : div_quo;
    assign rem_fix   = neg_rem_q ? (W'(0) - div_rem) : div_rem;

    logic [W-1:0] a_mag;
    logic [W-1:0] b_mag;

    assign a_mag = a[W-1] ? (W'(0) - a) : a;
    assign b_mag = b[W-1] ? (W'(0) - b) : b;

    // State and datapath register
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mcand_q     <= '0;
            acc_q       <= '0;
            mq_q        <= '0;
            qm1_q       <= 1'b0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            c           <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            acc_q       <= acc_d;
            mq_q        <= mq_d;
            qm1_q       <= qm1_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            busy        <= busy_d;
            done        <= done_d;
            c           <= c_d;
            div_by_zero <= dbz_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        qm1_d     = qm1_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        c_d       = c;
        dbz_d     = div_by_zero;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dbz_d = 1'b0;
                    case (opcode)
                        OP_MUL: begin
                            state_d = S_MUL;
                            cnt_d   = LW'(W - 1);
                            mcand_d = {a[W-1], a};
                            acc_d   = '0;
                            mq_d    = b;
                            qm1_d   = 1'b0;
                        end
                        OP_DIV: begin
                            if (b == '0) begin
                                c_d    = '0;
                                dbz_d  = 1'b1;
                                done_d = 1'b1;
                            end else begin
                                state_d   = S_DIV;
                                cnt_d     = LW'(W - 1);
                                dvs_d     = b_mag;
                                rem_d     = '0;
                                quo_d     = a_mag;
                                neg_quo_d = a[W-1] ^ b[W-1];
                                neg_rem_d = a[W-1];
                            end
                        end
                        default: begin
                            c_d    = {W'(0), alu_lo};
                            done_d = 1'b1;
                        end
                    endcase
                end
            end
            S_MUL: begin
                acc_d = booth_acc;
                mq_d  = booth_mq;
                qm1_d = mq_q[0];
                if (cnt_q == '0) begin
                    c_d     = {booth_acc[W-1:0], booth_mq};
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - LW'(1);
                end
            end
            S_DIV: begin
                rem_d = div_rem;
                quo_d = div_quo;
                if (cnt_q == '0) begin
                    c_d     = {rem_fix, quo_fix};
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - LW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: W=32 instance for ops, timing and reset,
// W=8 instance for a signed mul/div sweep against integer arithmetic.
module tb_alu_multicycle;

    localparam logic [4:0] ADD = 5'b00001, SUB = 5'b00010, MUL = 5'b00011, DIV = 5'b00100;
    localparam logic [4:0] SHR = 5'b00101, SHL = 5'b00110, SHRA = 5'b00111, ROR = 5'b01000;
    localparam logic [4:0] ROL = 5'b01001, AND_ = 5'b01010, OR_ = 5'b01011, NEG = 5'b01100;
    localparam logic [4:0] XOR_ = 5'b01101, NOR_ = 5'b01110, NOT_ = 5'b01111, UNDEF = 5'b10000;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        start;
    logic [4:0]  opcode;
    logic [31:0] a, b;
    logic        busy, done, dbz;
    logic [63:0] c;

    logic        start8;
    logic [4:0]  opcode8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, dbz8;
    logic [15:0] c8;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_multicycle #(.WORD_SIZE(32)) dut (
        .clk(clk), .clr_n(clr_n), .start(start), .opcode(opcode), .a(a), .b(b),
        .busy(busy), .done(done), .c(c), .div_by_zero(dbz)
    );

    alu_multicycle #(.WORD_SIZE(8)) dut8 (
        .clk(clk), .clr_n(clr_n), .start(start8), .opcode(opcode8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .c(c8), .div_by_zero(dbz8)
    );

    // Single-cycle vector table: opcode, a, b, expected LO (HI expected zero)
    localparam int NS = 14;
    logic [4:0]  s_op [NS] = '{UNDEF, ADD, SUB, SHRA, SHR, ROR, ROL, SHL, AND_, OR_, XOR_, NOR_, NEG, NOT_};
    logic [31:0] s_a  [NS] = '{32'h1, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h80000000, 32'h1, 32'h80000000,
                               32'h1, 32'hF0F0, 32'hF0F0, 32'hFFFF0000, 32'h0, 32'd5, 32'h0F0F0F0F};
    logic [31:0] s_b  [NS] = '{32'h2, 32'h1, 32'd7, 32'd4, 32'd4, 32'd1, 32'd1,
                               32'd33, 32'hFF00, 32'h0F0F, 32'hFF00FF00, 32'h0, 32'h0, 32'h0};
    logic [31:0] s_e  [NS] = '{32'h0, 32'h0, 32'hFFFFFFFE, 32'hF8000000, 32'h08000000, 32'h80000000, 32'h1,
                               32'h2, 32'hF000, 32'hFFFF, 32'h00FFFF00, 32'hFFFFFFFF, 32'hFFFFFFFB, 32'hF0F0F0F0};

    task automatic start32(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        opcode = op; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called in cycle t+1; returns the cycle index at which done is seen
    task automatic wait_done32(output int lat, output bit busy_bad, output bit c_bad);
        logic [63:0] c0;
        c0 = c; lat = 1; busy_bad = 1'b0; c_bad = 1'b0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy !== 1'b1) busy_bad = 1'b1;
            if (c !== c0) c_bad = 1'b1;
            @(negedge clk);
            lat++;
        end
        if (busy !== 1'b0) busy_bad = 1'b1;
    endtask

    task automatic test_reset;
        clr_n = 1'b0; start = 1'b0; opcode = '0; a = '0; b = '0;
        start8 = 1'b0; opcode8 = '0; a8 = '0; b8 = '0;
        repeat (3) @(negedge clk);
        tests++;
        if ({busy, done, dbz, c} !== 67'd0) begin
            fails++; $display("FAIL reset32: got %h required 0", {busy, done, dbz, c});
        end
        tests++;
        if ({busy8, done8, dbz8, c8} !== 19'd0) begin
            fails++; $display("FAIL reset8: got %h required 0", {busy8, done8, dbz8, c8});
        end
        clr_n = 1'b1;
    endtask

    task automatic test_single;
        for (int i = 0; i < NS; i++) begin
            start32(s_op[i], s_a[i], s_b[i]);
            tests++;
            if (done !== 1'b1 || c !== {32'h0, s_e[i]}) begin
                fails++; $display("FAIL single[%0d] op=%b: got done=%b c=%h required done=1 c=%h",
                                  i, s_op[i], done, c, {32'h0, s_e[i]});
            end
            @(negedge clk);
            tests++;
            if (done !== 1'b0) begin
                fails++; $display("FAIL single_done_low[%0d]: got %b required 0", i, done);
            end
        end
    endtask

    task automatic test_reset_mid_mul;
        bit seen;
        start32(MUL, 32'd7, 32'hFFFFFFFD);
        repeat (9) @(negedge clk);
        clr_n = 1'b0;
        #1;
        tests++;
        if ({busy, done, c} !== 66'd0) begin
            fails++; $display("FAIL reset_mid_mul: got busy=%b done=%b c=%h required all 0", busy, done, c);
        end
        @(negedge clk);
        clr_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        tests++;
        if (seen) begin
            fails++; $display("FAIL reset_discard: got done/busy activity after reset required none");
        end
    endtask

    task automatic test_mul;
        logic [31:0] ma [3] = '{32'd7, 32'h80000000, 32'h7FFFFFFF};
        logic [31:0] mb [3] = '{32'hFFFFFFFD, 32'h80000000, 32'h7FFFFFFF};
        logic [63:0] me [3] = '{64'hFFFFFFFF_FFFFFFEB, 64'h40000000_00000000, 64'h3FFFFFFF_00000001};
        int lat; bit bb, cb;
        for (int i = 0; i < 3; i++) begin
            start32(MUL, ma[i], mb[i]);
            wait_done32(lat, bb, cb);
            tests++;
            if (lat !== 33 || bb || cb) begin
                fails++; $display("FAIL mul_timing[%0d]: got lat=%0d busy_bad=%b c_bad=%b required lat=33", i, lat, bb, cb);
            end
            tests++;
            if (c !== me[i]) begin
                fails++; $display("FAIL mul_result[%0d]: got %h required %h", i, c, me[i]);
            end
        end
    endtask

    task automatic test_div;
        logic [31:0] da [2] = '{32'hFFFFFFF9, 32'h80000000};
        logic [31:0] db [2] = '{32'd2, 32'hFFFFFFFF};
        logic [63:0] de [2] = '{64'hFFFFFFFF_FFFFFFFD, 64'h00000000_80000000};
        int lat; bit bb, cb;
        for (int i = 0; i < 2; i++) begin
            start32(DIV, da[i], db[i]);
            wait_done32(lat, bb, cb);
            tests++;
            if (lat !== 33 || bb || cb) begin
                fails++; $display("FAIL div_timing[%0d]: got lat=%0d busy_bad=%b c_bad=%b required lat=33", i, lat, bb, cb);
            end
            tests++;
            if (c !== de[i] || dbz !== 1'b0) begin
                fails++; $display("FAIL div_result[%0d]: got c=%h dbz=%b required c=%h dbz=0", i, c, dbz, de[i]);
            end
        end
    endtask

    task automatic test_div_by_zero;
        start32(DIV, 32'd5, 32'd0);
        tests++;
        if (done !== 1'b1 || dbz !== 1'b1 || c !== 64'd0) begin
            fails++; $display("FAIL div0: got done=%b dbz=%b c=%h required done=1 dbz=1 c=0", done, dbz, c);
        end
        @(negedge clk);
        tests++;
        if (dbz !== 1'b1 || done !== 1'b0) begin
            fails++; $display("FAIL div0_hold: got dbz=%b done=%b required dbz=1 done=0", dbz, done);
        end
        start32(ADD, 32'd1, 32'd1);
        tests++;
        if (dbz !== 1'b0 || c !== 64'd2) begin
            fails++; $display("FAIL div0_clear: got dbz=%b c=%h required dbz=0 c=2", dbz, c);
        end
    endtask

    task automatic test_back_to_back;
        int lat; bit bb;
        start32(DIV, 32'd100, 32'd7);
        lat = 1; bb = 1'b0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy !== 1'b1) bb = 1'b1;
            opcode = ADD; a = 32'd50; b = 32'd60;
            start = (lat % 3 == 0 && lat < 30);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        tests++;
        if (lat !== 33 || bb) begin
            fails++; $display("FAIL busy_ignore_timing: got lat=%0d busy_bad=%b required lat=33", lat, bb);
        end
        tests++;
        if (c !== {32'd2, 32'd14}) begin
            fails++; $display("FAIL busy_ignore_result: got %h required %h", c, {32'd2, 32'd14});
        end
        // Start asserted in the done cycle is accepted immediately
        opcode = ADD; a = 32'd3; b = 32'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests++;
        if (done !== 1'b1 || c !== 64'd7) begin
            fails++; $display("FAIL back_to_back: got done=%b c=%h required done=1 c=7", done, c);
        end
    endtask

    task automatic test_sweep8;
        logic [7:0]  x, y;
        logic [4:0]  op;
        logic [15:0] exp;
        int xi, yi, lat;
        for (int i = 0; i < 40; i++) begin
            x = 8'($urandom); y = 8'($urandom);
            if (i == 0) begin x = 8'h80; y = 8'hFF; end
            if (i == 1) begin x = 8'h80; y = 8'h80; end
            op = (i % 2 == 0) ? DIV : MUL;
            if (op == DIV && y == 8'h0) y = 8'h1;
            xi = $signed(x); yi = $signed(y);
            if (op == MUL) exp = 16'(xi * yi);
            else           exp = {8'(xi % yi), 8'(xi / yi)};
            @(negedge clk);
            opcode8 = op; a8 = x; b8 = y; start8 = 1'b1;
            @(negedge clk);
            start8 = 1'b0;
            lat = 1;
            while (done8 !== 1'b1 && lat < 40) begin
                @(negedge clk);
                lat++;
            end
            tests++;
            if (lat !== 9) begin
                fails++; $display("FAIL sweep8_lat[%0d]: got %0d required 9", i, lat);
            end
            tests++;
            if (c8 !== exp) begin
                fails++; $display("FAIL sweep8[%0d] op=%b a=%h b=%h: got %h required %h", i, op, x, y, c8, exp);
            end
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_reset_mid_mul;
        test_mul;
        test_div;
        test_div_by_zero;
        test_back_to_back;
        test_sweep8;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
